hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Parametrised successor to the single-cycle load-use detector. Sits beside the
//  ID stage and drives all pipeline stall/bubble/flush controls. Adds a
//  multi-bubble load-use stall (LOAD_LAT), full-pipeline freeze on data-memory
//  busy, and IF/ID squash on a taken branch.
// PARAMETERS
//  REG_W     3  register specifier width (2**REG_W architectural regs)
//  LOAD_LAT  1  bubbles inserted per load-use hazard (1..7)
//  CNT_W     16 width of stall performance counter (HAZARD_PERF_CNT_EN only)
// PORTS
//  clk             in  1      clock
//  rst             in  1      sync reset, active high
//  MemRead_id_ex   in  1      load in EX
//  Rt_id_ex        in  REG_W  load destination
//  Rt_valid_id_ex  in  1      Rt_id_ex is a real write target
//  Rs_if_id        in  REG_W  ID source 1
//  Rs_valid_if_id  in  1      Rs_if_id is read
//  Rt_if_id        in  REG_W  ID source 2
//  Rt_valid_if_id  in  1      Rt_if_id is read
//  mem_busy        in  1      data memory not ready this cycle
//  branch_taken    in  1      EX resolved a taken branch/jump
//  PCWrite         out 1      1 = PC may update
//  IF_ID_Write     out 1      1 = IF/ID may update
//  zero_control_signals out 1 1 = load bubble into ID/EX
//  IF_ID_flush     out 1      1 = IF/ID loads NOP
//  pipe_hold       out 1      1 = ID/EX, EX/MEM, MEM/WB hold their contents
//  stall_cycles    out CNT_W  load-use + mem-wait cycle count (macro only)
// BEHAVIOUR
//  - Reset (rst=1): state=IDLE, bub_cnt=0, ret_state=IDLE, stall_cycles=0; outputs
//    forced to PCWrite=1, IF_ID_Write=1, all others 0, regardless of inputs.
//  - Outputs combinational from state + inputs; state updates on posedge clk.
//  - detect = MemRead_id_ex & ((Rt_id_ex==Rs_if_id & Rt_valid_id_ex & Rs_valid_if_id)
//    | (Rt_id_ex==Rt_if_id & Rt_valid_id_ex & Rt_valid_if_id)); full REG_W compare.
//  - Priority each cycle: mem_busy > branch_taken > load-use.
//  - States: IDLE, LU_STALL, MEM_WAIT.
//  - IDLE: mem_busy -> pipe_hold=1, PCWrite=0, IF_ID_Write=0, zero=0;
//    ret_state<=IDLE; next MEM_WAIT. Else branch_taken -> IF_ID_flush=1, zero=1,
//    PC updates; stay IDLE. Else detect -> PCWrite=0, IF_ID_Write=0, zero=1;
//    if LOAD_LAT>1 bub_cnt<=LOAD_LAT-1, next LU_STALL; else stay IDLE.
//  - LU_STALL: PCWrite=0, IF_ID_Write=0, zero=1; bub_cnt decrements; at
//    bub_cnt==1 next IDLE. detect is ignored (ID/EX already bubbled).
//    branch_taken aborts: flush outputs, bub_cnt<=0, next IDLE.
//    mem_busy: hold outputs as MEM_WAIT, bub_cnt frozen, ret_state<=LU_STALL.
//  - MEM_WAIT: pipe_hold=1, PCWrite=0, IF_ID_Write=0, zero=0, flush=0;
//    leaves on first cycle mem_busy=0 to ret_state (same-cycle outputs
//    per ret_state rules). branch_taken ignored while frozen (EX is held).
//  - Load-use total stall = exactly LOAD_LAT cycles excluding frozen cycles.
//  - rst mid-stall: next cycle IDLE, bub_cnt=0, any pending stall dropped.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: stall_cycles increments (saturating at all-ones)
//    every cycle PCWrite=0 and rst=0; cleared by rst.
//  Undefined: counter not built; stall_cycles tied to 0.
// TESTING
//  1 LOAD_LAT=1, MemRead=1, Rt_id_ex=3=Rs_if_id, valids=1 -> 1 cycle PCWrite=0, zero=1.
//  2 LOAD_LAT=3, same hazard -> PCWrite=0/zero=1 for exactly 3 cycles, then 1/0.
//  3 Rt_id_ex=3=Rs_if_id but Rs_valid_if_id=0 -> no stall; PCWrite=1.
//  4 LOAD_LAT=3, mem_busy=1 for 2 cycles in 2nd bubble -> pipe_hold=1 2 cycles,
//    zero=0 during hold, total PCWrite=0 for 5 cycles.
//  5 detect & branch_taken same cycle -> IF_ID_flush=1, zero=1, PCWrite=1, state IDLE.
//  6 rst=1 during LU_STALL -> next cycle outputs idle; macro on: stall_cycles=0.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline hazard-control bundle: ID/EX operand info and memory/branch status in, stall/flush controls out.
// The controller binds to the slave modport; the pipeline (or a bench) binds to master.
interface hazard_stall_ctrl_if #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
);
  logic             MemRead_id_ex;
  logic [REG_W-1:0] Rt_id_ex;
  logic             Rt_valid_id_ex;
  logic [REG_W-1:0] Rs_if_id;
  logic             Rs_valid_if_id;
  logic [REG_W-1:0] Rt_if_id;
  logic             Rt_valid_if_id;
  logic             mem_busy;
  logic             branch_taken;
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             zero_control_signals;
  logic             IF_ID_flush;
  logic             pipe_hold;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output MemRead_id_ex, Rt_id_ex, Rt_valid_id_ex,
    output Rs_if_id, Rs_valid_if_id, Rt_if_id, Rt_valid_if_id,
    output mem_busy, branch_taken,
    input  PCWrite, IF_ID_Write, zero_control_signals, IF_ID_flush, pipe_hold,
    input  stall_cycles
  );

  modport slave (
    input  MemRead_id_ex, Rt_id_ex, Rt_valid_id_ex,
    input  Rs_if_id, Rs_valid_if_id, Rt_if_id, Rt_valid_if_id,
    input  mem_busy, branch_taken,
    output PCWrite, IF_ID_Write, zero_control_signals, IF_ID_flush, pipe_hold,
    output stall_cycles
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/bubble/flush controller: multi-bubble load-use stall, memory-busy freeze, branch squash.
// Outputs are combinational from state + inputs. Optional stall counter under macro HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
  parameter int REG_W    = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_stall_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [2:0] BUB_INIT = 3'(LOAD_LAT - 1);

  state_t     r_state, w_next, r_ret, w_ret_next, w_eff;
  logic [2:0] r_bub, w_bub_next;
  logic       w_detect;
  logic       w_src1_hit, w_src2_hit;
  logic       w_pcw, w_ifw, w_zero, w_flush, w_hold;

  assign w_src1_hit = (hz.Rt_id_ex == hz.Rs_if_id) & hz.Rt_valid_id_ex & hz.Rs_valid_if_id;
  assign w_src2_hit = (hz.Rt_id_ex == hz.Rt_if_id) & hz.Rt_valid_id_ex & hz.Rt_valid_if_id;
  assign w_detect   = hz.MemRead_id_ex & (w_src1_hit | w_src2_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ret   <= IDLE;
      r_bub   <= 3'd0;
    end else begin
      r_state <= w_next;
      r_ret   <= w_ret_next;
      r_bub   <= w_bub_next;
    end
  end

  // Leaving MEM_WAIT applies the resumed state's rules in that same cycle.
  always_comb begin
    w_next     = r_state;
    w_ret_next = r_ret;
    w_bub_next = r_bub;
    w_pcw      = 1'b1;
    w_ifw      = 1'b1;
    w_zero     = 1'b0;
    w_flush    = 1'b0;
    w_hold     = 1'b0;
    w_eff      = (r_state == MEM_WAIT) ? r_ret : r_state;

    if (hz.mem_busy) begin
      w_pcw      = 1'b0;
      w_ifw      = 1'b0;
      w_hold     = 1'b1;
      w_next     = MEM_WAIT;
      w_ret_next = w_eff;
    end else begin
      w_next = IDLE;
      case (w_eff)
        LU_STALL: begin
          if (hz.branch_taken) begin
            w_flush    = 1'b1;
            w_zero     = 1'b1;
            w_bub_next = 3'd0;
          end else begin
            w_pcw  = 1'b0;
            w_ifw  = 1'b0;
            w_zero = 1'b1;
            if (r_bub <= 3'd1) begin
              w_bub_next = 3'd0;
            end else begin
              w_bub_next = r_bub - 3'd1;
              w_next     = LU_STALL;
            end
          end
        end
        default: begin
          if (hz.branch_taken) begin
            w_flush = 1'b1;
            w_zero  = 1'b1;
          end else if (w_detect) begin
            w_pcw  = 1'b0;
            w_ifw  = 1'b0;
            w_zero = 1'b1;
            if (LOAD_LAT > 1) begin
              w_bub_next = BUB_INIT;
              w_next     = LU_STALL;
            end
          end
        end
      endcase
    end
  end

  // Reset forces the pass-through output pattern regardless of inputs.
  assign hz.PCWrite              = rst | w_pcw;
  assign hz.IF_ID_Write          = rst | w_ifw;
  assign hz.zero_control_signals = ~rst & w_zero;
  assign hz.IF_ID_flush          = ~rst & w_flush;
  assign hz.pipe_hold            = ~rst & w_hold;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (!w_pcw && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign hz.stall_cycles = r_stall_cycles;
`else
  assign hz.stall_cycles = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench: LOAD_LAT=1 instance driven from a vector table, LOAD_LAT=3 instance by hand sequences.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.REG_W(3), .CNT_W(16)) hz1 ();
  hazard_stall_ctrl_if #(.REG_W(3), .CNT_W(16)) hz3 ();

  hazard_stall_ctrl #(.REG_W(3), .LOAD_LAT(1), .CNT_W(16)) u_dut1 (.clk(clk), .rst(rst), .hz(hz1));
  hazard_stall_ctrl #(.REG_W(3), .LOAD_LAT(3), .CNT_W(16)) u_dut3 (.clk(clk), .rst(rst), .hz(hz3));

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic       rst;
    logic       mr;
    logic [2:0] rtx;
    logic       rtxv;
    logic [2:0] rs;
    logic       rsv;
    logic [2:0] rt;
    logic       rtv;
    logic       mb;
    logic       br;
  } in_t;

  typedef struct {
    in_t        in;
    logic [4:0] exp;  // {PCWrite, IF_ID_Write, zero, flush, hold}
    string      nm;
  } vec_t;

  localparam logic [4:0] O_RUN = 5'b11000;
  localparam logic [4:0] O_LU  = 5'b00100;
  localparam logic [4:0] O_BR  = 5'b11110;
  localparam logic [4:0] O_MW  = 5'b00001;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];

  function automatic in_t mk(input logic r, input logic mr, input logic [2:0] rtx, input logic rtxv,
                             input logic [2:0] rs, input logic rsv, input logic [2:0] rt,
                             input logic rtv, input logic mb, input logic br);
    in_t v;
    v.rst = r; v.mr = mr; v.rtx = rtx; v.rtxv = rtxv; v.rs = rs; v.rsv = rsv;
    v.rt = rt; v.rtv = rtv; v.mb = mb; v.br = br;
    return v;
  endfunction

  function automatic in_t haz(input logic mb, input logic br);
    return mk(1'b0, 1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 3'd5, 1'b1, mb, br);
  endfunction

  function automatic in_t nop(input logic r, input logic mb, input logic br);
    return mk(r, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, mb, br);
  endfunction

  task automatic add(input in_t v, input logic [4:0] e, input string nm);
    vec_t t;
    t.in = v; t.exp = e; t.nm = nm;
    tbl.push_back(t);
  endtask

  task automatic drive(input in_t v);
    rst = v.rst;
    hz1.MemRead_id_ex = v.mr;   hz3.MemRead_id_ex = v.mr;
    hz1.Rt_id_ex = v.rtx;       hz3.Rt_id_ex = v.rtx;
    hz1.Rt_valid_id_ex = v.rtxv; hz3.Rt_valid_id_ex = v.rtxv;
    hz1.Rs_if_id = v.rs;        hz3.Rs_if_id = v.rs;
    hz1.Rs_valid_if_id = v.rsv; hz3.Rs_valid_if_id = v.rsv;
    hz1.Rt_if_id = v.rt;        hz3.Rt_if_id = v.rt;
    hz1.Rt_valid_if_id = v.rtv; hz3.Rt_valid_if_id = v.rtv;
    hz1.mem_busy = v.mb;        hz3.mem_busy = v.mb;
    hz1.branch_taken = v.br;    hz3.branch_taken = v.br;
  endtask

  // One clock: drive after the rising edge, compare at the falling edge.
  task automatic run(input in_t v, input bit d3, input logic [4:0] e, input string nm);
    logic [4:0] got;
    drive(v);
    @(negedge clk);
    got = d3 ? {hz3.PCWrite, hz3.IF_ID_Write, hz3.zero_control_signals, hz3.IF_ID_flush, hz3.pipe_hold}
             : {hz1.PCWrite, hz1.IF_ID_Write, hz1.zero_control_signals, hz1.IF_ID_flush, hz1.pipe_hold};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s got=%b exp=%b (pcw,ifw,zero,flush,hold)", nm, got, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sc(input bit d3, input logic [15:0] e, input string nm);
    logic [15:0] got;
    got = d3 ? hz3.stall_cycles : hz1.stall_cycles;
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s stall_cycles got=%0d exp=%0d", nm, got, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    add(mk(1, 1, 3'd3, 1, 3'd3, 1, 3'd5, 1, 1, 1), O_RUN, "rst_forced");
    add(nop(1, 0, 0),                               O_RUN, "rst_idle");
    add(haz(0, 0),                                  O_LU,  "lu_rs_lat1");
    add(nop(0, 0, 0),                               O_RUN, "lat1_one_cycle");
    add(mk(0, 1, 3'd3, 1, 3'd3, 0, 3'd5, 1, 0, 0), O_RUN, "rs_not_read");
    add(mk(0, 1, 3'd6, 1, 3'd1, 1, 3'd6, 1, 0, 0), O_LU,  "lu_rt_match");
    add(mk(0, 1, 3'd6, 1, 3'd1, 1, 3'd6, 0, 0, 0), O_RUN, "rt_not_read");
    add(mk(0, 1, 3'd3, 1, 3'd7, 1, 3'd7, 1, 0, 0), O_RUN, "msb_differs");
    add(mk(0, 0, 3'd3, 1, 3'd3, 1, 3'd3, 1, 0, 0), O_RUN, "no_memread");
    add(mk(0, 1, 3'd3, 0, 3'd3, 1, 3'd3, 1, 0, 0), O_RUN, "rt_ex_invalid");
    add(haz(0, 1),                                  O_BR,  "branch_over_lu");
    add(haz(1, 1),                                  O_MW,  "busy_over_all");
    add(nop(0, 1, 1),                               O_MW,  "busy_ignores_br");
    add(haz(0, 0),                                  O_LU,  "resume_idle_lu");
    add(nop(0, 0, 0),                               O_RUN, "after_resume");
    add(nop(0, 1, 0),                               O_MW,  "busy_again");
    add(nop(0, 0, 1),                               O_BR,  "resume_branch");
    add(nop(0, 0, 0),                               O_RUN, "table_end");

    for (int i = 0; i < tbl.size(); i++) run(tbl[i].in, 1'b0, tbl[i].exp, tbl[i].nm);
    chk_sc(1'b0, PERF ? 16'd6 : 16'd0, "sc_lat1");

    // LOAD_LAT=3: three bubbles, hazard still visible during the stall is ignored.
    run(nop(1, 0, 0), 1'b1, O_RUN, "l3_rst");
    run(haz(0, 0),    1'b1, O_LU,  "l3_bub1");
    run(haz(0, 0),    1'b1, O_LU,  "l3_bub2");
    run(haz(0, 0),    1'b1, O_LU,  "l3_bub3");
    run(nop(0, 0, 0), 1'b1, O_RUN, "l3_release");
    chk_sc(1'b1, PERF ? 16'd3 : 16'd0, "sc_l3_a");

    // Memory freeze during the second bubble stretches the stall to five cycles.
    run(haz(0, 0),    1'b1, O_LU,  "l3m_bub1");
    run(nop(0, 1, 0), 1'b1, O_MW,  "l3m_hold1");
    run(nop(0, 1, 1), 1'b1, O_MW,  "l3m_hold2");
    run(nop(0, 0, 0), 1'b1, O_LU,  "l3m_bub2");
    run(nop(0, 0, 0), 1'b1, O_LU,  "l3m_bub3");
    run(nop(0, 0, 0), 1'b1, O_RUN, "l3m_release");
    chk_sc(1'b1, PERF ? 16'd8 : 16'd0, "sc_l3_b");

    run(haz(0, 1),    1'b1, O_BR,  "l3_br_and_lu");
    run(nop(0, 0, 0), 1'b1, O_RUN, "l3_br_idle");

    run(haz(0, 0),    1'b1, O_LU,  "l3_abort_bub1");
    run(nop(0, 0, 1), 1'b1, O_BR,  "l3_abort_br");
    run(nop(0, 0, 0), 1'b1, O_RUN, "l3_abort_idle");

    run(haz(0, 0),                                  1'b1, O_LU,  "l3_rst_bub1");
    run(mk(1, 1, 3'd3, 1, 3'd3, 1, 3'd5, 1, 0, 0), 1'b1, O_RUN, "l3_rst_mid");
    run(nop(0, 0, 0),                               1'b1, O_RUN, "l3_rst_dropped");
    chk_sc(1'b1, 16'd0, "sc_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
